// File: rtl/mux_arbiter.sv
// Four-requester round-robin arbiter with a hold limit. It drives a registered one-hot grant,
// a mux select, and the selected data bit, which lags the grant by one cycle.
module mux_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       out,
  output logic       valid
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDXW = 2;
  localparam int unsigned CNTW = 4;

  typedef enum logic {IDLE, OWNED} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   sel_q, sel_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              out_q, out_d;
  logic              valid_q, valid_d;
  logic [NREQ-1:0]   data_vec;
  logic              grant_new;
  logic [IDXW-1:0]   owner_idx;

  assign data_vec = {i3, i2, i1, i0};

  // First set request bit, scanning from p upward with wrap-around.
  function automatic logic [IDXW-1:0] first_req(input logic [NREQ-1:0] r,
                                                input logic [IDXW-1:0] p);
    logic [IDXW-1:0] idx;
    first_req = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = p + IDXW'(k);
      if (r[idx]) first_req = idx;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    valid_d   = (state_q == OWNED);
    out_d     = (state_q == OWNED) ? data_vec[sel_q] : 1'b0;
    grant_new = 1'b0;
    owner_idx = '0;

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) grant_new = 1'b1;
      end
      OWNED: begin
        if (req[sel_q] && (cnt_q < CNTW'(HOLD_MAX))) begin
          cnt_d = cnt_q + CNTW'(1);
        end else begin
          // Release: the former owner drops to lowest priority.
          ptr_d = sel_q + IDXW'(1);
          if (|req) begin
            grant_new = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_new) begin
      owner_idx = first_req(req, ptr_d);
      state_d   = OWNED;
      sel_d     = owner_idx;
      gnt_d     = NREQ'(1) << owner_idx;
      cnt_d     = CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign out   = out_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed scenarios plus random traffic, scored against an
// ownership model built from integers.
module tb_mux_arbiter;

  localparam int unsigned HOLD = 4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       i0, i1, i2, i3;
  logic [3:0] gnt;
  logic       s1, s0, out, valid;

  int checks;
  int errors;

  // Model state: owner index, or -1 when there is no owner.
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;
  int m_out;
  int m_valid;

  mux_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .i0    (i0),
    .i1    (i1),
    .i2    (i2),
    .i3    (i3),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .out   (out),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic rst_v, input logic [3:0] req_v, input logic [3:0] dat_v);
    if (rst_v) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0; m_out = 0; m_valid = 0;
      return;
    end
    m_valid = (m_owner >= 0) ? 1 : 0;
    m_out   = (m_owner >= 0) ? int'(dat_v[m_owner]) : 0;
    if (m_owner < 0) begin
      if (req_v != 4'b0) begin
        m_owner = pick(req_v, m_ptr);
        m_cnt   = 1;
      end
    end else if (req_v[m_owner] && m_cnt < int'(HOLD)) begin
      m_cnt++;
    end else begin
      m_ptr = (m_owner + 1) % 4;
      if (req_v != 4'b0) begin
        m_owner = pick(req_v, m_ptr);
        m_cnt   = 1;
      end else begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end
    if (m_owner >= 0) m_sel = m_owner;
  endtask

  task automatic step(input logic rst_v, input logic [3:0] req_v, input logic [3:0] dat_v);
    logic [3:0] exp_gnt;
    reset = rst_v;
    req   = req_v;
    {i3, i2, i1, i0} = dat_v;
    @(posedge clk);
    model_edge(rst_v, req_v, dat_v);
    #1;
    exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("sel", 32'({s1, s0}), 32'(m_sel));
    check("out", 32'(out), 32'(m_out));
    check("valid", 32'(valid), 32'(m_valid));
    check("onehot", 32'($countones(gnt) <= 1), 32'(1));
  endtask

  logic [3:0] r_req;

  initial begin
    clk = 1'b0; reset = 1'b1; req = '0; {i3, i2, i1, i0} = '0;
    checks = 0; errors = 0;
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0; m_out = 0; m_valid = 0;

    // Reset, then one grant to requester 0
    step(1'b1, 4'b1111, 4'b1111);
    check("rst_outputs", 32'({gnt, s1, s0, out, valid}), 32'(0));
    step(1'b0, 4'b0001, 4'b0001);
    check("lat_gnt", 32'({gnt, s1, s0}), 32'(6'b000100));
    step(1'b0, 4'b0001, 4'b0001);
    check("lat_out", 32'({out, valid}), 32'(2'b11));

    // All requesting: each owner keeps the grant for HOLD cycles, with no gap between owners
    step(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 17; k++) begin
      step(1'b0, 4'b1111, 4'($urandom_range(0, 15)));
      check("rr_seq", 32'(gnt), 32'(1 << ((k / int'(HOLD)) % 4)));
    end

    // Owner 2 drops while 0 and 3 request: 3 is next after the release
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0100, 4'b0100);
    step(1'b0, 4'b1001, 4'b0000);
    check("ptr_after_drop", 32'(gnt), 32'(4'b1000));

    // A sole requester keeps the grant through the hold-count wrap
    step(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'b0100, 4'($urandom_range(0, 15)));
      check("sole_hold", 32'(gnt), 32'(4'b0100));
    end

    // Request falls to zero: the grant drops, then valid and out follow one cycle later
    step(1'b0, 4'b0000, 4'b1111);
    check("drop_gnt", 32'(gnt), 32'(0));
    step(1'b0, 4'b0000, 4'b1111);
    check("drop_valid", 32'({out, valid}), 32'(0));

    // Reset while requester 3 owns the mux: the first grant afterwards uses ptr 0 priority
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b1000, 4'b1000);
    step(1'b0, 4'b1000, 4'b1000);
    step(1'b1, 4'b1000, 4'b1000);
    check("midrst_zero", 32'({gnt, s1, s0, out, valid}), 32'(0));
    step(1'b0, 4'b1010, 4'b0000);
    check("post_rst_gnt", 32'(gnt), 32'(4'b0010));

    // Random traffic with sticky requests and occasional resets
    r_req = 4'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) < 3) r_req = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 63) == 0), r_req, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
